// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver, LSB first, with a one-entry
// valid/ready holding register and framing-error / overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 byte_done;

  // Two-flop synchroniser for the asynchronous line; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: start-bit validation, centre sampling of data and stop bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            // Shift in from the top so the first (LSB) bit ends at bit 0.
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state     <= IDLE;
              busy      <= 1'b0;
              byte_done <= 1'b1;
            end else begin
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line returns idle so a break is not decoded as zero bytes.
          if (rx_s) begin
            state   <= IDLE;
            clk_cnt <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load on completion, pop on handshake, flag overrun when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_byte  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor-owned observations
  int         cyc          = 0;
  int         hs_count     = 0;
  logic [7:0] hs_bytes[$];
  int         valid_cycles = 0;
  int         ferr_count   = 0;
  int         ovr_count    = 0;
  int         busy_cycles  = 0;
  int         rise_cyc     = -1;
  logic       prev_valid   = 1'b0;

  // Stimulus-owned bookkeeping
  int t_start;
  int hs0, ferr0, ovr0, busy0, val0;
  int lat;

  uart_rx #(
    .CLK_FREQ (1000000),
    .BAUD     (100000),
    .DATA_BITS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe outputs 1 time unit after each falling edge (after stimulus updates).
  always @(negedge clk) begin
    #1;
    if (rx_valid && rx_ready) begin
      hs_count++;
      hs_bytes.push_back(rx_byte);
    end
    if (rx_valid) valid_cycles++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (frame_err) ferr_count++;
    if (overrun) ovr_count++;
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    #2;
    hs0   = hs_count;
    ferr0 = ferr_count;
    ovr0  = ovr_count;
    busy0 = busy_cycles;
    val0  = valid_cycles;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_data = 1'b1;
    repeat (n - 1) @(negedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_data = f[i];
      if (i == 0) t_start = cyc;
      repeat (9) @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] fa;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_rx_byte", 32'(rx_byte), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // Single byte 0xA5 with rx_ready high
    snap();
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_handshakes", 32'(hs_count - hs0), 32'd1);
    check("a5_value", 32'(hs_bytes[hs0]), 32'hA5);
    check("a5_valid_single_cycle", 32'(valid_cycles - val0), 32'd1);
    lat = rise_cyc - t_start;
    check("a5_latency_97_to_99", 32'(lat >= 97 && lat <= 99), 32'd1);
    check("a5_no_frame_err", 32'(ferr_count - ferr0), 32'd0);
    check("a5_busy_idle", 32'(busy), 32'h0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_handshakes", 32'(hs_count - hs0), 32'd2);
    check("b2b_first", 32'(hs_bytes[hs0]), 32'h00);
    check("b2b_second", 32'(hs_bytes[hs0 + 1]), 32'hFF);
    check("b2b_no_frame_err", 32'(ferr_count - ferr0), 32'd0);
    check("b2b_no_overrun", 32'(ovr_count - ovr0), 32'd0);

    // 3-cycle low glitch on an idle line
    snap();
    @(negedge clk);
    rx_data = 1'b0;
    repeat (2) @(negedge clk);
    idle(15);
    check("glitch_busy_seen", 32'((busy_cycles - busy0) >= 1), 32'd1);
    check("glitch_busy_le6", 32'((busy_cycles - busy0) <= 6), 32'd1);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(valid_cycles - val0), 32'd0);
    check("glitch_no_frame_err", 32'(ferr_count - ferr0), 32'd0);

    // 0x3C with stop bit low, then line held low 40 cycles
    snap();
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    #2;
    check("ferr_pulse_once", 32'(ferr_count - ferr0), 32'd1);
    check("ferr_no_valid", 32'(valid_cycles - val0), 32'd0);
    check("ferr_busy_held", 32'(busy), 32'h1);
    idle(6);
    check("ferr_busy_released", 32'(busy), 32'h0);
    check("ferr_still_no_valid", 32'(valid_cycles - val0), 32'd0);

    // Overrun: rx_ready low, 0x11 then 0x22
    @(negedge clk);
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("ovr_valid_held", 32'(rx_valid), 32'h1);
    check("ovr_byte_kept", 32'(rx_byte), 32'h11);
    check("ovr_pulse_once", 32'(ovr_count - ovr0), 32'd1);
    check("ovr_no_handshake", 32'(hs_count - hs0), 32'd0);
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("ovr_pop_count", 32'(hs_count - hs0), 32'd1);
    check("ovr_pop_value", 32'(hs_bytes[hs0]), 32'h11);
    check("ovr_valid_dropped", 32'(rx_valid), 32'h0);
    idle(10);

    // Reset mid-DATA of 0x5A, then 0xC3
    snap();
    fa = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = fa[i];
      repeat (9) @(negedge clk);
    end
    #2;
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    rst     = 1'b1;
    rx_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_valid", 32'(rx_valid), 32'h0);
    check("rst_mid_byte", 32'(rx_byte), 32'h00);
    check("rst_mid_frame_err", 32'(frame_err), 32'h0);
    check("rst_mid_overrun", 32'(overrun), 32'h0);
    idle(20);
    send_frame(8'hC3, 1'b1);
    idle(20);
    check("rst_mid_one_byte", 32'(hs_count - hs0), 32'd1);
    check("rst_mid_c3", 32'(hs_bytes[hs0]), 32'hC3);
    check("rst_mid_no_frame_err", 32'(ferr_count - ferr0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
